ov7670_capture_stream: RTL and testbench
========================================

Name: ov7670_capture_stream

Overview:
Parametrised next-generation OV7670 capture front end in the pclk domain. Assembles byte pairs into 16-bit pixels and converts them per a runtime format mode. Writes each pixel to a frame BRAM and streams it on AXI4-Stream with frame-accurate tuser/tlast. Adds frame sync, line/frame geometry checking, backpressure overflow detection and frame status. Sits between the camera pins and the VDMA/BRAM frame buffer.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
ADDR_W, 19, BRAM address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT

Ports:
pclk  in  1  camera pixel clock, sole clock
capture_rst  in  1  synchronous active-high reset
enable  in  1  capture enable, sampled at frame start
mode  in  2  0=RGB565 pass, 1=RGB555, 2=Y-only grey, 3=reserved (treated as 0); sampled at frame start
vsync  in  1  camera vsync, active high
href  in  1  camera href, active high
d  in  8  camera data byte
bram_addr  out  ADDR_W  write address
bram_data  out  16  write data
bram_we  out  1  one-cycle write strobe
tdata  out  16  AXIS pixel
tvalid  out  1  AXIS valid
tready  in  1  AXIS ready
tuser  out  1  start of frame
tlast  out  1  end of line
frame_done  out  1  one-cycle pulse, frame completed with correct geometry
frame_err  out  1  one-cycle pulse, frame ended with wrong geometry or dropped pixels
overflow  out  1  sticky: a pixel was dropped by backpressure
frame_count  out  16  count of good frames, wraps at 65535->0

Behaviour:
- Reset: all outputs 0, FSM=WAIT_VS_HI, counters and byte phase 0. Reset applies mid-frame and is the only way to clear overflow.
- FSM WAIT_VS_HI: vsync=1 -> WAIT_VS_LO.
- FSM WAIT_VS_LO: vsync=0 -> ACTIVE if enable=1, else WAIT_VS_HI. Latch mode; clear row, col and the error flag.
- FSM ACTIVE: vsync=1 -> WAIT_VS_LO. If row==HEIGHT and the error flag is clear, pulse frame_done and increment frame_count; otherwise pulse frame_err. A partial first frame after reset is never captured.
- Bytes are captured only in ACTIVE with href=1. Byte phase toggles per byte and resets to 0 whenever href=0. Byte 0 is the high byte.
- A pixel is complete on the phase-1 byte. Conversion by mode:
  - RGB565: {hi,lo}.
  - RGB555: {1'b0, p[15:11], p[10:6], p[4:0]}.
  - Grey (YUYV, Y = hi byte): {Y[7:3], Y[7:2], Y[7:3]}.
- Latency: tdata/tvalid, bram_data/bram_we/bram_addr all register on the cycle after the phase-1 byte is sampled.
- col counts pixels per line. Pixels with col>=WIDTH are discarded (no write, no stream) and set the error flag.
- href 1->0 with col>0: row increments and col clears. col!=WIDTH sets the error flag. Lines with row>=HEIGHT are discarded and set the error flag.
- bram_addr = row*WIDTH+col, generated incrementally (no multiplier). bram_we is independent of tready.
- tuser=1 with the pixel at row 0, col 0. tlast=1 with the pixel at col WIDTH-1. Both are qualified with tvalid.
- AXIS: tvalid/tdata/tuser/tlast hold until tready=1.
- If a new pixel is produced while tvalid=1 and tready=0, the new pixel is dropped from the stream only (BRAM still written), overflow sets, and the error flag sets.
- New pixel and tready=1 in the same cycle: the new pixel loads and tvalid stays 1.
- vsync rising mid-line: the line is abandoned and the frame ends as above. A pending AXIS beat is still held until accepted.

Optional Feature:
DECIMATE_EN.
- Defined: adds input port decimate (1 bit), sampled at frame start. When 1, only even columns and even rows are kept. The effective geometry becomes WIDTH/2 x HEIGHT/2 for tlast, addressing and frame_done checks, with BRAM packed densely. When 0, behaviour is identical to the undefined case.
- Undefined: no decimate port; full resolution always.

Decomposition:
- Package ov7670_pkg holds the mode encodings and the FSM state enum.
- Sub-module ov7670_pix_fmt (combinational byte-pair to pixel conversion by mode) is natural.
- The FSM, counters and AXIS register remain in the top.

Test Plan:
- WIDTH=4, HEIGHT=2, mode 0, tready=1, bytes 0x12,0x34 repeated -> 8 beats of 0x1234; tuser on beat 0; tlast on beats 3 and 7; bram_addr 0..7; frame_done once; frame_count=1.
- Mode 1 on 0xFFFF -> 0x7FFF. Mode 2 with Y=0x80 -> 0x8410.
- tready=0 for the whole line -> the first pixel is held, later pixels are dropped, overflow=1, frame_err pulses, BRAM still gets all 4 writes.
- Short line (3 pixels) -> frame_err pulse, frame_count unchanged. Next clean frame -> frame_done.
- Reset asserted mid-line -> all outputs 0 next cycle. Capture resumes only after a full vsync high/low sequence.
- enable=0 at frame start -> no writes and no beats for that frame.

Source files
------------

// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared encodings for the OV7670 capture front end.
//   mode_e  : runtime pixel format selection (sampled at frame start)
//   state_e : frame-sync state machine states
package ov7670_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,
    MODE_RGB555 = 2'd1,
    MODE_GREY   = 2'd2,
    MODE_RSVD   = 2'd3   // behaves like RGB565
  } mode_e;

  typedef enum logic [1:0] {
    ST_WAIT_VS_HI = 2'd0,
    ST_WAIT_VS_LO = 2'd1,
    ST_ACTIVE     = 2'd2
  } state_e;

endpackage

// File: rtl/ov7670_pix_fmt.sv
// ov7670_pix_fmt: combinational byte-pair to 16-bit pixel conversion.
//   hi_i   : first (high) byte of the pair
//   lo_i   : second (low) byte of the pair
//   mode_i : output format
//   pix_o  : converted pixel
module ov7670_pix_fmt
  import ov7670_pkg::*;
(
  input  logic [7:0]  hi_i,
  input  logic [7:0]  lo_i,
  input  mode_e       mode_i,
  output logic [15:0] pix_o
);

  logic [15:0] raw;
  assign raw = {hi_i, lo_i};

  always_comb begin
    pix_o = raw;
    case (mode_i)
      // Drop the green LSB to fit 5:5:5 under a zero MSB.
      MODE_RGB555: pix_o = {1'b0, raw[15:11], raw[10:6], raw[4:0]};
      // YUYV: luma is the high byte; replicate into all three channels.
      MODE_GREY:   pix_o = {hi_i[7:3], hi_i[7:2], hi_i[7:3]};
      default:     pix_o = raw;
    endcase
  end

endmodule

// File: rtl/ov7670_capture_stream.sv
// ov7670_capture_stream: OV7670 capture front end in the pclk domain.
// Assembles byte pairs into pixels, converts them by mode, writes each pixel
// to a frame BRAM and streams it on AXI4-Stream with tuser (SOF) / tlast (EOL).
// Checks line/frame geometry, flags backpressure drops, counts good frames.
// Ports:
//   pclk, capture_rst         : clock, synchronous active-high reset
//   enable, mode[1:0]         : capture enable / pixel format, sampled at frame start
//   decimate                  : (only with DECIMATE_EN) keep even rows/cols only
//   vsync, href, d[7:0]       : camera pins
//   bram_addr/data/we         : frame buffer write port
//   tdata/tvalid/tready/tuser/tlast : AXI4-Stream master
//   frame_done, frame_err     : one-cycle end-of-frame status pulses
//   overflow                  : sticky backpressure drop flag
//   frame_count[15:0]         : good frame counter (wraps)
// Optional feature macro: DECIMATE_EN (adds the decimate input).
module ov7670_capture_stream
  import ov7670_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              pclk,
  input  logic              capture_rst,
  input  logic              enable,
  input  logic [1:0]        mode,
`ifdef DECIMATE_EN
  input  logic              decimate,
`endif
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [15:0]       bram_data,
  output logic              bram_we,
  output logic [15:0]       tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              tuser,
  output logic              tlast,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overflow,
  output logic [15:0]       frame_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0]     WIDTH_C     = CW'(WIDTH);
  localparam logic [CW-1:0]     LAST_COL_C  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]     LAST_EVEN_C = CW'(((WIDTH - 1) / 2) * 2);
  localparam logic [RW-1:0]     HEIGHT_C    = RW'(HEIGHT);
  localparam logic [ADDR_W-1:0] STEP_FULL   = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] STEP_HALF   = ADDR_W'((WIDTH + 1) / 2);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic                phase_q, phase_d;
  logic [7:0]          hi_q, hi_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]   base_q, base_d;   // row*line_step, kept incrementally
  logic                err_q, err_d;
  logic                tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic [15:0]         tdata_q, tdata_d, bdata_q, bdata_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   baddr_q, baddr_d;
  logic                done_q, done_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic [15:0]         fcnt_q, fcnt_d;

  logic decim;
`ifdef DECIMATE_EN
  logic decim_q, decim_d;
  assign decim = decim_q;
`else
  assign decim = 1'b0;
`endif

  logic          capture, pix_done, in_geom, dec_skip, last_col;
  logic [CW-1:0] eff_col;
  logic [15:0]   pix;

  // Bytes arriving together with vsync belong to an abandoned line.
  assign capture  = (state_q == ST_ACTIVE) && href && !vsync;
  assign pix_done = capture && phase_q;
  assign in_geom  = (col_q < WIDTH_C) && (row_q < HEIGHT_C);
  assign dec_skip = decim && (col_q[0] || row_q[0]);
  assign eff_col  = decim ? (col_q >> 1) : col_q;
  assign last_col = decim ? (col_q == LAST_EVEN_C) : (col_q == LAST_COL_C);

  ov7670_pix_fmt u_fmt (
    .hi_i   (hi_q),
    .lo_i   (d),
    .mode_i (mode_q),
    .pix_o  (pix)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    phase_d  = 1'b0;
    hi_d     = hi_q;
    col_d    = col_q;
    row_d    = row_q;
    base_d   = base_q;
    err_d    = err_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    we_d     = 1'b0;
    bdata_d  = bdata_q;
    baddr_d  = baddr_q;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    ovf_d    = ovf_q;
    fcnt_d   = fcnt_q;
`ifdef DECIMATE_EN
    decim_d  = decim_q;
`endif

    // AXIS beat retires independently of the capture state.
    if (tvalid_q && tready) tvalid_d = 1'b0;

    if (capture) begin
      phase_d = ~phase_q;
      if (!phase_q) hi_d = d;
    end

    case (state_q)
      ST_WAIT_VS_HI: if (vsync) state_d = ST_WAIT_VS_LO;
      ST_WAIT_VS_LO: if (!vsync) begin
        state_d = enable ? ST_ACTIVE : ST_WAIT_VS_HI;
        mode_d  = mode_e'(mode);
        col_d   = '0;
        row_d   = '0;
        base_d  = '0;
        err_d   = 1'b0;
`ifdef DECIMATE_EN
        decim_d = decimate;
`endif
      end
      ST_ACTIVE: begin
        if (vsync) begin
          state_d = ST_WAIT_VS_LO;
          if (row_q == HEIGHT_C && !err_q) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
          end else begin
            ferr_d = 1'b1;
          end
        end else if (pix_done) begin
          // col saturates at WIDTH: anything beyond is already an error.
          if (col_q != WIDTH_C) col_d = col_q + CW'(1);
          if (!in_geom) begin
            err_d = 1'b1;
          end else if (!dec_skip) begin
            we_d    = 1'b1;
            bdata_d = pix;
            baddr_d = base_q + ADDR_W'(eff_col);
            if (!tvalid_q || tready) begin
              tvalid_d = 1'b1;
              tdata_d  = pix;
              tuser_d  = (row_q == '0) && (col_q == '0);
              tlast_d  = last_col;
            end else begin
              // Stream slot still occupied: drop from the stream only.
              ovf_d = 1'b1;
              err_d = 1'b1;
            end
          end
        end else if (!href && col_q != '0) begin
          col_d = '0;
          if (row_q != HEIGHT_C) row_d = row_q + RW'(1);
          // Odd rows are not stored when decimating, so they do not advance the base.
          if (row_q < HEIGHT_C && !(decim && row_q[0]))
            base_d = base_q + (decim ? STEP_HALF : STEP_FULL);
          if (col_q != WIDTH_C || row_q >= HEIGHT_C) err_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT_VS_HI;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (capture_rst) begin
      state_q  <= ST_WAIT_VS_HI;
      mode_q   <= MODE_RGB565;
      phase_q  <= 1'b0;
      hi_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      base_q   <= '0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      we_q     <= 1'b0;
      bdata_q  <= '0;
      baddr_q  <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fcnt_q   <= '0;
`ifdef DECIMATE_EN
      decim_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      hi_q     <= hi_d;
      col_q    <= col_d;
      row_q    <= row_d;
      base_q   <= base_d;
      err_q    <= err_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      we_q     <= we_d;
      bdata_q  <= bdata_d;
      baddr_q  <= baddr_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      fcnt_q   <= fcnt_d;
`ifdef DECIMATE_EN
      decim_q  <= decim_d;
`endif
    end
  end

  assign bram_addr   = baddr_q;
  assign bram_data   = bdata_q;
  assign bram_we     = we_q;
  assign tdata       = tdata_q;
  assign tvalid      = tvalid_q;
  assign tuser       = tuser_q;
  assign tlast       = tlast_q;
  assign frame_done  = done_q;
  assign frame_err   = ferr_q;
  assign overflow    = ovf_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_ov7670_capture_stream.sv
// tb_ov7670_capture_stream: randomized frames checked against a frame-level
// model (expected BRAM writes, AXIS beats and frame status per frame).
module tb_ov7670_capture_stream;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int ADDR_W = 3;

  logic              pclk = 1'b0;
  logic              capture_rst = 1'b1;
  logic              enable = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              vsync = 1'b0;
  logic              href = 1'b0;
  logic [7:0]        d = 8'd0;
  logic [ADDR_W-1:0] bram_addr;
  logic [15:0]       bram_data;
  logic              bram_we;
  logic [15:0]       tdata;
  logic              tvalid;
  logic              tready = 1'b1;
  logic              tuser;
  logic              tlast;
  logic              frame_done;
  logic              frame_err;
  logic              overflow;
  logic [15:0]       frame_count;

  ov7670_capture_stream #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
    .pclk        (pclk),
    .capture_rst (capture_rst),
    .enable      (enable),
    .mode        (mode),
    .vsync       (vsync),
    .href        (href),
    .d           (d),
    .bram_addr   (bram_addr),
    .bram_data   (bram_data),
    .bram_we     (bram_we),
    .tdata       (tdata),
    .tvalid      (tvalid),
    .tready      (tready),
    .tuser       (tuser),
    .tlast       (tlast),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: only this process writes these.
  logic [31:0] act_wr[$];
  logic [17:0] act_beat[$];
  int done_cnt = 0;
  int err_cnt  = 0;

  always @(negedge pclk) begin
    if (bram_we) act_wr.push_back({16'(bram_addr), bram_data});
    if (tvalid && tready) act_beat.push_back({tuser, tlast, tdata});
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
  end

  // Frame configuration used by run_frame.
  int         line_len[8];
  int         n_lines;
  bit         fixed;
  bit         stall0;
  logic [7:0] fix_hi, fix_lo;
  logic [15:0] first_beat;
  int         fcnt_model = 0;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [15:0] conv(input logic [7:0] hb, input logic [7:0] lb,
                                       input logic [1:0] m);
    int p, r, g, b, y5, y6;
    p = hb * 256 + lb;
    case (m)
      2'd1: begin
        r = p / 2048; g = (p / 64) % 32; b = p % 32;
        return 16'(r * 1024 + g * 32 + b);
      end
      2'd2: begin
        y5 = hb / 8; y6 = hb / 4;
        return 16'(y5 * 2048 + y6 * 32 + y5);
      end
      default: return 16'(p);
    endcase
  endfunction

  task automatic run_frame(input bit en, input logic [1:0] m);
    logic [31:0] exp_wr[$];
    logic [17:0] exp_beat[$];
    int wr_base, beat_base, done_base, err_base;
    bit good;
    logic [7:0] hb, lb;
    logic [15:0] px;

    vsync = 1'b1; tick(); tick();
    wr_base = act_wr.size(); beat_base = act_beat.size();
    done_base = done_cnt; err_base = err_cnt;
    enable = en; mode = m; vsync = 1'b0; tick(); tick();
    good = (n_lines == HEIGHT);
    for (int r = 0; r < n_lines; r++) begin
      if (line_len[r] != WIDTH) good = 1'b0;
      if (stall0 && r == 0) tready = 1'b0;
      for (int c = 0; c < line_len[r]; c++) begin
        hb = fixed ? fix_hi : 8'($urandom);
        lb = fixed ? fix_lo : 8'($urandom);
        href = 1'b1; d = hb; tick();
        d = lb; tick();
        if (en && r < HEIGHT && c < WIDTH) begin
          px = conv(hb, lb, m);
          exp_wr.push_back({16'(r * WIDTH + c), px});
          if (!(stall0 && r == 0 && c > 0))
            exp_beat.push_back({(r == 0 && c == 0), (c == WIDTH - 1), px});
        end
      end
      href = 1'b0; d = 8'd0; tick(); tick();
      if (stall0 && r == 0) begin
        check("stall_hold_valid", 32'(tvalid), 32'd1);
        check("stall_hold_data", 32'(tdata), (exp_wr.size() > 0) ? exp_wr[0] & 32'hFFFF : 32'hDEAD);
        check("stall_ovf", 32'(overflow), 32'd1);
        tready = 1'b1;
        good = 1'b0;
      end
    end
    vsync = 1'b1; tick(); tick(); tick();
    if (en && good) fcnt_model = (fcnt_model + 1) % 65536;

    check("wr_count", act_wr.size() - wr_base, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && wr_base + i < act_wr.size(); i++)
      check($sformatf("wr[%0d]", i), act_wr[wr_base + i], exp_wr[i]);
    check("beat_count", act_beat.size() - beat_base, exp_beat.size());
    for (int i = 0; i < exp_beat.size() && beat_base + i < act_beat.size(); i++)
      check($sformatf("beat[%0d]", i), 32'(act_beat[beat_base + i]), 32'(exp_beat[i]));
    check("frame_done", done_cnt - done_base, (en && good) ? 1 : 0);
    check("frame_err", err_cnt - err_base, (en && !good) ? 1 : 0);
    check("frame_count", 32'(frame_count), 32'(fcnt_model));
    first_beat = (act_beat.size() > beat_base) ? act_beat[beat_base][15:0] : 16'hDEAD;
    $display("[TB] frame en=%0d mode=%0d lines=%0d writes=%0d beats=%0d done=%0d err=%0d",
             en, m, n_lines, act_wr.size() - wr_base, act_beat.size() - beat_base,
             done_cnt - done_base, err_cnt - err_base);
  endtask

  task automatic set_clean();
    n_lines = HEIGHT;
    for (int r = 0; r < 8; r++) line_len[r] = WIDTH;
    fixed = 1'b0; stall0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_base, beat_base;
    tick(); tick(); tick();
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_we", 32'(bram_we), 32'd0);
    check("rst_outs", {tdata, bram_data}, 32'd0);
    check("rst_misc", {26'd0, bram_addr, tuser, tlast, frame_done, frame_err, overflow}, 32'd0);
    check("rst_fcnt", 32'(frame_count), 32'd0);
    capture_rst = 1'b0; tick();

    // Directed formats.
    set_clean(); fixed = 1'b1; fix_hi = 8'h12; fix_lo = 8'h34;
    run_frame(1'b1, 2'd0);
    check("rgb565_px", 32'(first_beat), 32'h1234);
    fix_hi = 8'hFF; fix_lo = 8'hFF;
    run_frame(1'b1, 2'd1);
    check("rgb555_px", 32'(first_beat), 32'h7FFF);
    fix_hi = 8'h80; fix_lo = 8'h3C;
    run_frame(1'b1, 2'd2);
    check("grey_px", 32'(first_beat), 32'h8410);

    // Randomized frames.
    for (int f = 0; f < 14; f++) begin
      set_clean();
      n_lines = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : HEIGHT;
      for (int r = 0; r < n_lines; r++)
        line_len[r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : WIDTH;
      run_frame($urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)));
    end

    // Short line, then a clean frame.
    set_clean(); line_len[0] = 3;
    run_frame(1'b1, 2'd0);
    set_clean();
    run_frame(1'b1, 2'd0);

    // Backpressure for the whole first line.
    check("ovf_before", 32'(overflow), 32'd0);
    set_clean(); stall0 = 1'b1;
    run_frame(1'b1, 2'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Capture disabled.
    set_clean();
    run_frame(1'b0, 2'd0);

    // Reset mid-line.
    vsync = 1'b1; tick(); tick();
    enable = 1'b1; vsync = 1'b0; tick(); tick();
    href = 1'b1; d = 8'hAA; tick(); d = 8'h55; tick(); d = 8'hAA; tick();
    capture_rst = 1'b1; tick();
    check("midrst_valid_we", {tvalid, bram_we}, 32'd0);
    check("midrst_data", {tdata, bram_data}, 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_fcnt", 32'(frame_count), 32'd0);
    fcnt_model = 0;
    capture_rst = 1'b0;
    wr_base = act_wr.size(); beat_base = act_beat.size();
    for (int i = 0; i < 6; i++) begin d = 8'(i); tick(); end
    href = 1'b0; tick(); tick();
    href = 1'b1;
    for (int i = 0; i < 8; i++) begin d = 8'(i); tick(); end
    href = 1'b0; tick(); tick();
    check("midrst_no_wr", act_wr.size() - wr_base, 0);
    check("midrst_no_beat", act_beat.size() - beat_base, 0);

    set_clean();
    run_frame(1'b1, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
